// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU,
// beq, jal). Per-state control bits are held in registers that are loaded
// together with the state register. The ALU decoder, the immediate-format
// select and the branch-qualified PC write are combinational.
//
// Optional build macro: BNE_SUPPORT_EN
//   defined   : funct3[0] inverts the branch condition, so bne is supported.
//   undefined : the branch condition ignores funct3; every branch acts as beq.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BEQ      = STATE_W'(9),
        JAL      = STATE_W'(10)
    } state_t;

    // Control bits owned by a state; registered alongside the state itself.
    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       done;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    logic   state_legal_s;
    logic   illegal_s;
    logic   strobe_en_s;
    logic   branch_cond_s;

    // Moore control word for a given state; unlisted fields stay zero.
    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
            DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            MEMREAD: begin
                c.adrsrc = 1'b1;
            end
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
                c.done      = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
                c.done     = 1'b1;
            end
            EXECUTER: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b00;
                c.aluop   = 2'b10;
            end
            EXECUTEI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b10;
            end
            ALUWB: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            BEQ: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b00;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
                c.done    = 1'b1;
            end
            JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // True for the six opcodes this core executes.
    function automatic logic legal_op(input logic [6:0] o);
        logic ok;
        case (o)
            OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state selection; anything unexpected falls back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH: next_state_s = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_R:         next_state_s = EXECUTER;
                    OP_I:         next_state_s = EXECUTEI;
                    OP_BR:        next_state_s = BEQ;
                    OP_JAL:       next_state_s = JAL;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (op[5]) begin
                    next_state_s = MEMWRITE;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMREAD:  next_state_s = MEMWB;
            EXECUTER: next_state_s = ALUWB;
            EXECUTEI: next_state_s = ALUWB;
            JAL:      next_state_s = ALUWB;
            MEMWB:    next_state_s = FETCH;
            MEMWRITE: next_state_s = FETCH;
            ALUWB:    next_state_s = FETCH;
            BEQ:      next_state_s = FETCH;
            default:  next_state_s = FETCH;
        endcase
    end

    // Flags whether the state register holds one of the defined encodings.
    always_comb begin
        state_legal_s = 1'b0;
        case (state_r)
            FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
            EXECUTER, EXECUTEI, ALUWB, BEQ, JAL: state_legal_s = 1'b1;
            default:                             state_legal_s = 1'b0;
        endcase
    end

    // State register and its registered control word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            ctrl_r  <= ctrl_for_state(FETCH);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_for_state(next_state_s);
        end
    end

    // Strobes are killed while reset is held and in any corrupted state.
    assign strobe_en_s = ~reset & state_legal_s;
    assign illegal_s   = (state_r == DECODE) & ~legal_op(op);

`ifdef BNE_SUPPORT_EN
    assign branch_cond_s = Zero ^ funct3[0];
`else
    assign branch_cond_s = Zero;
`endif

    assign PCWrite   = strobe_en_s & (ctrl_r.pcupdate | (ctrl_r.branch & branch_cond_s));
    assign MemWrite  = strobe_en_s & ctrl_r.memwrite;
    assign IRWrite   = strobe_en_s & ctrl_r.irwrite;
    assign RegWrite  = strobe_en_s & ctrl_r.regwrite;
    assign InstrDone = strobe_en_s & (ctrl_r.done | illegal_s);
    assign Illegal   = strobe_en_s & illegal_s;
    assign AdrSrc    = ctrl_r.adrsrc;
    assign ResultSrc = ctrl_r.resultsrc;
    assign ALUSrcA   = ctrl_r.alusrca;
    assign ALUSrcB   = ctrl_r.alusrcb;

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder: add for address/PC math, sub for compare, funct3 for execute.
    always_comb begin
        ALUControl = 3'b000;
        case (ctrl_r.aluop)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] & funct7b5) begin
                            ALUControl = 3'b001;
                        end else begin
                            ALUControl = 3'b000;
                        end
                    end
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. For each instruction the
// expected per-cycle control vector is pushed to a scoreboard queue, then
// popped and compared against the DUT once per cycle on the falling edge.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state codes (bench-private).
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BEQ = 9, S_JAL = 10;

    logic [17:0] exp_q[$];
    int          st_q[$];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal};
    endfunction

    function automatic logic op_known(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    endfunction

    function automatic int model_next(input int s, input logic [6:0] o);
        int n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                if (o == 7'b0000011 || o == 7'b0100011) n = S_MEMADR;
                else if (o == 7'b0110011)               n = S_EXECR;
                else if (o == 7'b0010011)               n = S_EXECI;
                else if (o == 7'b1100011)               n = S_BEQ;
                else if (o == 7'b1101111)               n = S_JAL;
                else                                    n = S_FETCH;
            end
            S_MEMADR:  n = o[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: n = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: n = S_ALUWB;
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    // Expected control vector for one cycle, written from the state table.
    function automatic logic [17:0] model_out(input int s, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7,
                                              input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, dn, il;
        logic [1:0] rs, sa, sb, imm, aop;
        logic [2:0] ac;
        logic bcond;
        {pcw, adr, mw, irw, rw, dn, il} = 7'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
`ifdef BNE_SUPPORT_EN
        bcond = z ^ f3[0];
`else
        bcond = z;
`endif
        case (s)
            S_FETCH:    begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; il = ~op_known(o); dn = il; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  begin adr = 1'b1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; dn = 1'b1; end
            S_EXECR:    begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_ALUWB:    begin rw = 1'b1; dn = 1'b1; end
            S_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = bcond; dn = 1'b1; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default:    begin end
        endcase
        if (rst) {pcw, mw, irw, rw, dn, il} = 6'b0;
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            if (f3 == 3'b000)      ac = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
            else                   ac = 3'b000;
        end else ac = 3'b000;
        if (o == 7'b0100011)      imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        else                      imm = 2'b00;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, dn, il};
    endfunction

    // Push one instruction's expected cycles, then pop/compare one per cycle.
    // stop_at >= 0 truncates the instruction after that state (for reset tests).
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int stop_at);
        int s;
        int n;
        int done_cnt;
        s = S_FETCH; n = 0;
        do begin
            exp_q.push_back(model_out(s, o, f3, f7, z, 1'b0));
            st_q.push_back(s);
            n++;
            if (s == stop_at) break;
            s = model_next(s, o);
        end while (s != S_FETCH && n < 8);
        done_cnt = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            op = o; funct3 = f3; funct7b5 = f7; Zero = z;
            #1;
            check_value($sformatf("%s st%0d", name, st_q.pop_front()),
                        32'(observed()), 32'(exp_q.pop_front()));
            done_cnt += int'(InstrDone);
        end
        if (stop_at < 0) check_value({name, " retire count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(negedge clk); #1;
        check_value("reset outputs", 32'(observed()),
                    32'(model_out(S_FETCH, op, funct3, funct7b5, Zero, 1'b1)));
        @(posedge clk); #1 reset = 1'b0;

        run_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        run_instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b1, -1);
        run_instr("add",    7'b0110011, 3'b000, 1'b0, 1'b0, -1);
        run_instr("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("and",    7'b0110011, 3'b111, 1'b0, 1'b0, -1);
        run_instr("or",     7'b0110011, 3'b110, 1'b0, 1'b0, -1);
        run_instr("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        run_instr("addi7",  7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        run_instr("ori",    7'b0010011, 3'b110, 1'b0, 1'b0, -1);
        run_instr("slli",   7'b0010011, 3'b001, 1'b0, 1'b0, -1);
        run_instr("beq z1", 7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run_instr("beq z0", 7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run_instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, -1);
        run_instr("illegal",7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        run_instr("lw2",    7'b0000011, 3'b010, 1'b0, 1'b1, -1);

        // Reset asserted in the middle of a store's MEMWRITE cycle.
        run_instr("sw cut", 7'b0100011, 3'b010, 1'b0, 1'b0, S_MEMWRITE);
        #2 reset = 1'b1;
        #1;
        check_value("reset in MEMWRITE", 32'(observed()),
                    32'(model_out(S_FETCH, op, funct3, funct7b5, Zero, 1'b1)));
        @(negedge clk); #1;
        check_value("reset held MemWrite", 32'(MemWrite), 32'd0);
        check_value("reset held vector", 32'(observed()),
                    32'(model_out(S_FETCH, op, funct3, funct7b5, Zero, 1'b1)));
        @(posedge clk); #1 reset = 1'b0;
        run_instr("after reset", 7'b0110011, 3'b000, 1'b1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
